fetch_queue_unit: RTL and testbench

Front-end fetch block for the superscalar core. Each cycle it drives eight consecutive word addresses into the 8-port read-only instruction memory and captures the eight returned instruction words. It buffers them with their PCs in a circular instruction queue and presents up to four in-order instructions per cycle to decode. It owns the fetch PC and handles redirects from branch resolution by flushing the queue.

---
 rtl/fetch_queue_unit.sv | 181 ++++++++++++++++++
 tb/tb_fetch_queue_unit.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue_unit.sv
// fetch_queue_unit: owns the fetch PC, issues 8-word fetch blocks to an 8-port
// instruction memory, and buffers the returned words with their PCs in a
// circular queue. Decode sees the oldest four entries. Fetch-to-decode
// latency is 1 cycle.
// Backpressure: a block is fetched only if 8 entries are free (registered
// count); otherwise the ports idle and stall_cnt counts the blocked cycle.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   imem_addr1..8 / imem_rd1..8   fetch addresses out, instruction words in
//   redirect_valid, redirect_pc   flush the queue and restart fetch at target
//   dec_take                      instructions consumed by decode (clamped)
//   dq_valid, dq_instr0..3,
//   dq_pc0..3                     oldest four entries, slot 0 oldest
//   stall_cnt                     cycles blocked by a full queue
module fetch_queue_unit #(
   parameter int          DEPTH     = 16,
   parameter logic [31:0] RESET_PC  = 32'h0,
   parameter logic [31:0] IDLE_ADDR = 32'h0000ffff
) (
   input  logic        clk,
   input  logic        rst,
   output logic [31:0] imem_addr1,
   output logic [31:0] imem_addr2,
   output logic [31:0] imem_addr3,
   output logic [31:0] imem_addr4,
   output logic [31:0] imem_addr5,
   output logic [31:0] imem_addr6,
   output logic [31:0] imem_addr7,
   output logic [31:0] imem_addr8,
   input  logic [31:0] imem_rd1,
   input  logic [31:0] imem_rd2,
   input  logic [31:0] imem_rd3,
   input  logic [31:0] imem_rd4,
   input  logic [31:0] imem_rd5,
   input  logic [31:0] imem_rd6,
   input  logic [31:0] imem_rd7,
   input  logic [31:0] imem_rd8,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   input  logic [2:0]  dec_take,
   output logic [3:0]  dq_valid,
   output logic [31:0] dq_instr0,
   output logic [31:0] dq_instr1,
   output logic [31:0] dq_instr2,
   output logic [31:0] dq_instr3,
   output logic [31:0] dq_pc0,
   output logic [31:0] dq_pc1,
   output logic [31:0] dq_pc2,
   output logic [31:0] dq_pc3,
   output logic [31:0] stall_cnt
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] ISSUE_MAX = CNT_W'(DEPTH - 8);

   logic [31:0]      pc_q, pc_d;
   logic [PTR_W-1:0] head_q, head_d;
   logic [PTR_W-1:0] tail_q, tail_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [31:0]      stall_q, stall_d;
   logic [31:0]      instr_q [DEPTH];
   logic [31:0]      instr_d [DEPTH];
   logic [31:0]      pcs_q   [DEPTH];
   logic [31:0]      pcs_d   [DEPTH];

   logic        issue;
   logic [2:0]  avail;
   logic [2:0]  take_eff;
   logic [31:0] fetch_addr [8];
   logic [31:0] rd         [8];
   logic [31:0] slot_instr [4];
   logic [31:0] slot_pc    [4];

   assign rd[0] = imem_rd1;
   assign rd[1] = imem_rd2;
   assign rd[2] = imem_rd3;
   assign rd[3] = imem_rd4;
   assign rd[4] = imem_rd5;
   assign rd[5] = imem_rd6;
   assign rd[6] = imem_rd7;
   assign rd[7] = imem_rd8;

   // Issue depends only on registered occupancy, so decode never has a
   // combinational path to the memory addresses.
   always_comb begin
      issue = !rst && !redirect_valid && (count_q <= ISSUE_MAX);
      for (int k = 0; k < 8; k++) begin
         fetch_addr[k] = pc_q + 32'(4 * k);
      end
   end

   assign imem_addr1 = issue ? fetch_addr[0] : IDLE_ADDR;
   assign imem_addr2 = issue ? fetch_addr[1] : IDLE_ADDR;
   assign imem_addr3 = issue ? fetch_addr[2] : IDLE_ADDR;
   assign imem_addr4 = issue ? fetch_addr[3] : IDLE_ADDR;
   assign imem_addr5 = issue ? fetch_addr[4] : IDLE_ADDR;
   assign imem_addr6 = issue ? fetch_addr[5] : IDLE_ADDR;
   assign imem_addr7 = issue ? fetch_addr[6] : IDLE_ADDR;
   assign imem_addr8 = issue ? fetch_addr[7] : IDLE_ADDR;

   // Decode view: slot K is head+K; valid is a thermometer of count, forced
   // off while reset is asserted so a mid-run reset hides stale entries.
   always_comb begin
      for (int k = 0; k < 4; k++) begin
         slot_instr[k] = instr_q[head_q + PTR_W'(k)];
         slot_pc[k]    = pcs_q[head_q + PTR_W'(k)];
         dq_valid[k]   = !rst && (count_q > CNT_W'(k));
      end
   end

   assign dq_instr0 = slot_instr[0];
   assign dq_instr1 = slot_instr[1];
   assign dq_instr2 = slot_instr[2];
   assign dq_instr3 = slot_instr[3];
   assign dq_pc0    = slot_pc[0];
   assign dq_pc1    = slot_pc[1];
   assign dq_pc2    = slot_pc[2];
   assign dq_pc3    = slot_pc[3];
   assign stall_cnt = stall_q;

   // Over-asking decode is clamped to what is actually visible.
   always_comb begin
      avail    = (count_q >= CNT_W'(4)) ? 3'd4 : count_q[2:0];
      take_eff = (dec_take > avail) ? avail : dec_take;
   end

   always_comb begin
      pc_d    = pc_q;
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      stall_d = stall_q;
      instr_d = instr_q;
      pcs_d   = pcs_q;
      if (redirect_valid) begin
         // Flush wins over pop and fetch; the cycle is not a stall.
         pc_d    = redirect_pc & 32'hffff_fffc;
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         if (count_q > ISSUE_MAX) begin
            stall_d = stall_q + 32'd1;
         end
         head_d = head_q + PTR_W'(take_eff);
         if (issue) begin
            for (int k = 0; k < 8; k++) begin
               instr_d[tail_q + PTR_W'(k)] = rd[k];
               pcs_d[tail_q + PTR_W'(k)]   = fetch_addr[k];
            end
            tail_d = tail_q + PTR_W'(8);
            pc_d   = pc_q + 32'd32;
         end
         count_d = count_q + (issue ? CNT_W'(8) : CNT_W'(0)) - CNT_W'(take_eff);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q    <= RESET_PC;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         stall_q <= '0;
      end else begin
         pc_q    <= pc_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         stall_q <= stall_d;
      end
   end

   // Queue storage needs no reset: validity comes from count alone.
   always_ff @(posedge clk) begin
      instr_q <= instr_d;
      pcs_q   <= pcs_d;
   end

endmodule

// File: tb/tb_fetch_queue_unit.sv
module tb_fetch_queue_unit;

   localparam int          DEPTH     = 16;
   localparam logic [31:0] RESET_PC  = 32'h0;
   localparam logic [31:0] IDLE_ADDR = 32'h0000ffff;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] imem_addr1, imem_addr2, imem_addr3, imem_addr4;
   logic [31:0] imem_addr5, imem_addr6, imem_addr7, imem_addr8;
   logic [31:0] imem_rd1, imem_rd2, imem_rd3, imem_rd4;
   logic [31:0] imem_rd5, imem_rd6, imem_rd7, imem_rd8;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic [2:0]  dec_take;
   logic [3:0]  dq_valid;
   logic [31:0] dq_instr0, dq_instr1, dq_instr2, dq_instr3;
   logic [31:0] dq_pc0, dq_pc1, dq_pc2, dq_pc3;
   logic [31:0] stall_cnt;

   int n_checks = 0;
   int n_err    = 0;

   // Reference state: scoreboard of queued PCs plus fetch PC and stall count.
   logic [31:0] sb_pc [$];
   logic [31:0] m_pc;
   logic [31:0] m_stall;

   logic [31:0] o_pc    [4];
   logic [31:0] o_instr [4];

   always #5 clk = ~clk;

   // Memory: word n holds n; the idle address reads 0.
   function automatic logic [31:0] mem(input logic [31:0] a);
      return (a == IDLE_ADDR) ? 32'h0 : (a >> 2);
   endfunction

   function automatic logic [3:0] therm(input int n);
      return (n >= 4) ? 4'b1111 : (n == 3) ? 4'b0111 : (n == 2) ? 4'b0011 :
             (n == 1) ? 4'b0001 : 4'b0000;
   endfunction

   assign imem_rd1 = mem(imem_addr1);
   assign imem_rd2 = mem(imem_addr2);
   assign imem_rd3 = mem(imem_addr3);
   assign imem_rd4 = mem(imem_addr4);
   assign imem_rd5 = mem(imem_addr5);
   assign imem_rd6 = mem(imem_addr6);
   assign imem_rd7 = mem(imem_addr7);
   assign imem_rd8 = mem(imem_addr8);

   always_comb begin
      o_pc[0] = dq_pc0;  o_pc[1] = dq_pc1;  o_pc[2] = dq_pc2;  o_pc[3] = dq_pc3;
      o_instr[0] = dq_instr0; o_instr[1] = dq_instr1;
      o_instr[2] = dq_instr2; o_instr[3] = dq_instr3;
   end

   fetch_queue_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC), .IDLE_ADDR(IDLE_ADDR)) dut (
      .clk(clk), .rst(rst),
      .imem_addr1(imem_addr1), .imem_addr2(imem_addr2), .imem_addr3(imem_addr3),
      .imem_addr4(imem_addr4), .imem_addr5(imem_addr5), .imem_addr6(imem_addr6),
      .imem_addr7(imem_addr7), .imem_addr8(imem_addr8),
      .imem_rd1(imem_rd1), .imem_rd2(imem_rd2), .imem_rd3(imem_rd3), .imem_rd4(imem_rd4),
      .imem_rd5(imem_rd5), .imem_rd6(imem_rd6), .imem_rd7(imem_rd7), .imem_rd8(imem_rd8),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .dec_take(dec_take),
      .dq_valid(dq_valid),
      .dq_instr0(dq_instr0), .dq_instr1(dq_instr1), .dq_instr2(dq_instr2), .dq_instr3(dq_instr3),
      .dq_pc0(dq_pc0), .dq_pc1(dq_pc1), .dq_pc2(dq_pc2), .dq_pc3(dq_pc3),
      .stall_cnt(stall_cnt)
   );

   // Apply inputs after the falling edge; outputs settle 1 time unit later.
   task automatic drive(input logic r, input logic [2:0] t, input logic rv,
                        input logic [31:0] rp);
      @(negedge clk);
      rst = r; dec_take = t; redirect_valid = rv; redirect_pc = rp;
      #1;
   endtask

   // Advance the reference for the driven inputs, then take the rising edge.
   task automatic tick();
      int n, av, te;
      if (rst) begin
         sb_pc.delete(); m_pc = RESET_PC; m_stall = 0;
      end else if (redirect_valid) begin
         sb_pc.delete(); m_pc = redirect_pc & ~32'h3;
      end else begin
         n  = sb_pc.size();
         av = (n > 4) ? 4 : n;
         te = (int'(dec_take) > av) ? av : int'(dec_take);
         if (n > DEPTH - 8) m_stall = m_stall + 1;
         repeat (te) void'(sb_pc.pop_front());
         if (n <= DEPTH - 8) begin
            for (int k = 0; k < 8; k++) sb_pc.push_back(m_pc + 32'(4 * k));
            m_pc = m_pc + 32'd32;
         end
      end
      @(posedge clk);
   endtask

   task automatic do_reset();
      drive(1'b1, 3'd0, 1'b0, 32'h0); tick();
   endtask

   task automatic test_reset();
      drive(1'b1, 3'd0, 1'b0, 32'h0);
      n_checks++;
      if (dq_valid !== 4'b0000) begin n_err++; $display("FAIL rst_valid: got %b want 0000", dq_valid); end
      n_checks++;
      if (imem_addr1 !== IDLE_ADDR || imem_addr8 !== IDLE_ADDR) begin
         n_err++; $display("FAIL rst_addr: got %h/%h want %h", imem_addr1, imem_addr8, IDLE_ADDR);
      end
      tick();
      do_reset();
      drive(1'b0, 3'd0, 1'b0, 32'h0);   // cycle 0
      n_checks++;
      if (dq_valid !== 4'b0000 || stall_cnt !== 32'd0) begin
         n_err++; $display("FAIL cyc0_state: valid=%b stall=%0d want 0000/0", dq_valid, stall_cnt);
      end
      n_checks++;
      if (imem_addr1 !== RESET_PC || imem_addr4 !== RESET_PC + 32'hC || imem_addr8 !== RESET_PC + 32'h1C) begin
         n_err++; $display("FAIL cyc0_addr: got %h/%h/%h want 0/c/1c", imem_addr1, imem_addr4, imem_addr8);
      end
      tick();
   endtask

   // Continues from cycle 1 after test_reset with dec_take held at 0.
   task automatic test_fill_and_stall();
      drive(1'b0, 3'd0, 1'b0, 32'h0);   // cycle 1
      n_checks++;
      if (dq_valid !== 4'b1111) begin n_err++; $display("FAIL fill_valid: got %b want 1111", dq_valid); end
      for (int k = 0; k < 4; k++) begin
         n_checks++;
         if (o_instr[k] !== 32'(k) || o_pc[k] !== 32'(4 * k)) begin
            n_err++; $display("FAIL fill_slot%0d: instr=%h pc=%h want %h/%h", k, o_instr[k], o_pc[k], k, 4 * k);
         end
      end
      n_checks++;
      if (imem_addr1 !== 32'h20 || imem_addr8 !== 32'h3C) begin
         n_err++; $display("FAIL fill_addr2: got %h/%h want 20/3c", imem_addr1, imem_addr8);
      end
      tick();
      for (int c = 2; c < 7; c++) begin
         drive(1'b0, 3'd0, 1'b0, 32'h0);
         n_checks++;
         if (imem_addr1 !== IDLE_ADDR || dq_valid !== 4'b1111) begin
            n_err++; $display("FAIL full_hold c%0d: addr=%h valid=%b want idle/1111", c, imem_addr1, dq_valid);
         end
         n_checks++;
         if (stall_cnt !== 32'(c - 2)) begin
            n_err++; $display("FAIL stall_cnt c%0d: got %0d want %0d", c, stall_cnt, c - 2);
         end
         n_checks++;
         if (dq_instr0 !== 32'd0 || dq_pc3 !== 32'hC) begin
            n_err++; $display("FAIL full_keep c%0d: instr0=%h pc3=%h", c, dq_instr0, dq_pc3);
         end
         tick();
      end
   endtask

   // Queue is full here; over-asking decode pops exactly four.
   task automatic test_take_clamp();
      drive(1'b0, 3'd7, 1'b0, 32'h0);
      tick();
      drive(1'b0, 3'd0, 1'b0, 32'h0);
      n_checks++;
      if (dq_pc0 !== 32'h10 || dq_instr0 !== 32'h4) begin
         n_err++; $display("FAIL clamp_pop: pc0=%h instr0=%h want 10/4", dq_pc0, dq_instr0);
      end
      n_checks++;
      if (imem_addr1 !== IDLE_ADDR) begin n_err++; $display("FAIL clamp_noissue: addr=%h", imem_addr1); end
      tick();
   endtask

   task automatic test_redirect();
      do_reset();
      drive(1'b0, 3'd0, 1'b0, 32'h0); tick();
      drive(1'b0, 3'd0, 1'b0, 32'h0); tick();
      drive(1'b0, 3'd4, 1'b1, 32'h43);
      n_checks++;
      if (imem_addr1 !== IDLE_ADDR || imem_addr8 !== IDLE_ADDR) begin
         n_err++; $display("FAIL redir_same: got %h/%h want idle", imem_addr1, imem_addr8);
      end
      tick();
      drive(1'b0, 3'd0, 1'b0, 32'h0);
      n_checks++;
      if (dq_valid !== 4'b0000) begin n_err++; $display("FAIL redir_flush: valid=%b", dq_valid); end
      n_checks++;
      if (imem_addr1 !== 32'h40 || imem_addr8 !== 32'h5C) begin
         n_err++; $display("FAIL redir_addr: got %h/%h want 40/5c", imem_addr1, imem_addr8);
      end
      tick();
      drive(1'b0, 3'd0, 1'b0, 32'h0);
      n_checks++;
      if (dq_valid !== 4'b1111 || dq_pc0 !== 32'h40 || dq_instr0 !== 32'h10 || dq_pc3 !== 32'h4C) begin
         n_err++; $display("FAIL redir_first: valid=%b pc0=%h instr0=%h pc3=%h", dq_valid, dq_pc0, dq_instr0, dq_pc3);
      end
      tick();
   endtask

   task automatic test_back_to_back();
      do_reset();
      drive(1'b0, 3'd4, 1'b0, 32'h0);   // empty queue: take clamps to 0
      n_checks++;
      if (dq_valid !== 4'b0000) begin n_err++; $display("FAIL b2b_empty: valid=%b", dq_valid); end
      tick();
      for (int i = 1; i <= 12; i++) begin
         drive(1'b0, 3'd4, 1'b0, 32'h0);
         n_checks++;
         if (dq_valid !== 4'b1111 || dq_pc0 !== 32'(16 * (i - 1))) begin
            n_err++; $display("FAIL b2b c%0d: valid=%b pc0=%h want 1111/%h", i, dq_valid, dq_pc0, 16 * (i - 1));
         end
         n_checks++;
         if (sb_pc.size() == 0 || dq_pc3 !== sb_pc[3] || stall_cnt !== m_stall) begin
            n_err++; $display("FAIL b2b_sb c%0d: pc3=%h stall=%0d want stall %0d", i, dq_pc3, stall_cnt, m_stall);
         end
         tick();
      end
   endtask

   task automatic test_wrap();
      int issues = 0;
      int cyc = 0;
      int n, te;
      logic [2:0] t;
      logic [31:0] exp_pc = 32'hffff_fffc;
      do_reset();
      while (issues < 10 && cyc < 100) begin
         t = (cyc % 2 == 0) ? 3'd4 : 3'd2;
         drive(1'b0, t, 1'b0, 32'h0);
         n = sb_pc.size();
         te = (n > 4) ? 4 : n;
         if (int'(t) < te) te = int'(t);
         n_checks++;
         if (dq_valid !== therm(n)) begin
            n_err++; $display("FAIL wrap_valid c%0d: got %b want %b", cyc, dq_valid, therm(n));
         end
         for (int k = 0; k < te; k++) begin
            exp_pc = exp_pc + 32'd4;
            n_checks++;
            if (o_pc[k] !== exp_pc || o_instr[k] !== (exp_pc >> 2)) begin
               n_err++; $display("FAIL wrap_pop c%0d s%0d: pc=%h instr=%h want %h", cyc, k, o_pc[k], o_instr[k], exp_pc);
            end
         end
         if (n <= DEPTH - 8) issues++;
         tick();
         cyc++;
      end
      n_checks++;
      if (issues < 10) begin n_err++; $display("FAIL wrap_budget: issues=%0d want 10", issues); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      drive(1'b0, 3'd0, 1'b0, 32'h0); tick();
      drive(1'b0, 3'd4, 1'b0, 32'h0); tick();   // count now 12
      drive(1'b1, 3'd0, 1'b0, 32'h0);
      n_checks++;
      if (dq_valid !== 4'b0000 || imem_addr1 !== IDLE_ADDR) begin
         n_err++; $display("FAIL mid_rst: valid=%b addr=%h", dq_valid, imem_addr1);
      end
      tick();
      drive(1'b0, 3'd0, 1'b0, 32'h0);
      n_checks++;
      if (dq_valid !== 4'b0000 || stall_cnt !== 32'd0) begin
         n_err++; $display("FAIL mid_after: valid=%b stall=%0d", dq_valid, stall_cnt);
      end
      n_checks++;
      if (imem_addr1 !== RESET_PC || imem_addr8 !== RESET_PC + 32'h1C) begin
         n_err++; $display("FAIL mid_addr: got %h/%h", imem_addr1, imem_addr8);
      end
      tick();
   endtask

   initial begin
      rst = 1'b1; dec_take = 3'd0; redirect_valid = 1'b0; redirect_pc = 32'h0;
      m_pc = RESET_PC; m_stall = 0;
      test_reset();
      test_fill_and_stall();
      test_take_clamp();
      test_redirect();
      test_back_to_back();
      test_wrap();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
